// File: rtl/tmr_recovery_ctrl_pkg.sv
// Shared types and constants for the TMR recovery controller: FSM states,
// fault identifiers, voter agreement patterns and decode helpers.
package tmr_pkg;

  typedef enum logic [1:0] {
    MONITOR  = 2'd0,
    RESYNC   = 2'd1,
    ROLLBACK = 2'd2,
    FATAL    = 2'd3
  } state_t;

  localparam logic [1:0] FID_A    = 2'd0;
  localparam logic [1:0] FID_B    = 2'd1;
  localparam logic [1:0] FID_C    = 2'd2;
  localparam logic [1:0] FID_NONE = 2'd3;

  // Agreement bits are {AB,BC,AC}; a lone surviving pair names the odd replica out.
  localparam logic [2:0] VS_CLEAN = 3'b111;
  localparam logic [2:0] VS_A_BAD = 3'b010;
  localparam logic [2:0] VS_B_BAD = 3'b001;
  localparam logic [2:0] VS_C_BAD = 3'b100;

  function automatic logic [1:0] vs_to_fid(input logic [2:0] vs);
    case (vs)
      VS_A_BAD: return FID_A;
      VS_B_BAD: return FID_B;
      VS_C_BAD: return FID_C;
      default:  return FID_NONE;
    endcase
  endfunction

  function automatic logic [2:0] fid_to_rst(input logic [1:0] fid);
    case (fid)
      FID_A:   return 3'b100;
      FID_B:   return 3'b010;
      FID_C:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tmr_recovery_ctrl_if.sv
// Voter-side and replica-side signal bundle for the recovery controller.
// TMR_ERR_LOG_EN adds the per-replica error counters to the bundle.
interface tmr_recovery_ctrl_if
`ifdef TMR_ERR_LOG_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic        commit;
  logic        stall;
  logic [2:0]  replica_rst;
  logic        rollback_en;
  logic [31:0] rollback_pc;
  logic [1:0]  fault_id;
  logic        fatal;
`ifdef TMR_ERR_LOG_EN
  logic [CNT_W-1:0] err_cnt_a;
  logic [CNT_W-1:0] err_cnt_b;
  logic [CNT_W-1:0] err_cnt_c;
  logic [CNT_W-1:0] err_cnt_multi;

  modport master (
    input  voter_state, pc_voted, commit,
    output stall, replica_rst, rollback_en, rollback_pc, fault_id, fatal,
    output err_cnt_a, err_cnt_b, err_cnt_c, err_cnt_multi
  );
  modport slave (
    output voter_state, pc_voted, commit,
    input  stall, replica_rst, rollback_en, rollback_pc, fault_id, fatal,
    input  err_cnt_a, err_cnt_b, err_cnt_c, err_cnt_multi
  );
`else
  modport master (
    input  voter_state, pc_voted, commit,
    output stall, replica_rst, rollback_en, rollback_pc, fault_id, fatal
  );
  modport slave (
    output voter_state, pc_voted, commit,
    input  stall, replica_rst, rollback_en, rollback_pc, fault_id, fatal
  );
`endif
endinterface

// File: rtl/tmr_ckpt_tracker.sv
// Counts clean commits and captures the voted PC as the rollback target
// every CKPT_INTERVAL commits; the counter restarts after each rollback.
module tmr_ckpt_tracker #(
  parameter int          CKPT_INTERVAL = 16,
  parameter logic [31:0] RESET_PC      = 32'h0
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        commit_clean,
  input  logic        clear,
  input  logic [31:0] pc_voted,
  output logic        ckpt_taken,
  output logic [31:0] rollback_pc
);
  localparam int CW = $clog2(CKPT_INTERVAL);

  logic [CW-1:0] cnt_reg;

  assign ckpt_taken = commit_clean && (cnt_reg == CW'(CKPT_INTERVAL - 1));

  always_ff @(posedge clk) begin
    if (rst_in) begin
      cnt_reg     <= '0;
      rollback_pc <= RESET_PC;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (commit_clean) begin
      if (ckpt_taken) begin
        cnt_reg     <= '0;
        rollback_pc <= pc_voted;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery FSM: isolates a single faulty replica or rolls the triple back,
// going fatal after MAX_RETRY rollbacks without a checkpoint. Optional
// error counters are built when TMR_ERR_LOG_EN is defined.
module tmr_recovery_ctrl
  import tmr_pkg::*;
#(
  parameter int          RESYNC_CYCLES = 4,
  parameter int          CKPT_INTERVAL = 16,
  parameter int          MAX_RETRY     = 3,
  parameter logic [31:0] RESET_PC      = 32'h0
`ifdef TMR_ERR_LOG_EN
  ,
  parameter int          CNT_W         = 8
`endif
) (
  input  logic                clk,
  input  logic                rst_in,
  tmr_recovery_ctrl_if.master bus
);
  localparam int RW  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int RCW = $clog2(RESYNC_CYCLES + 1);

  state_t         state_reg;
  logic [RW-1:0]  retry_reg;
  logic [RCW-1:0] rs_cnt_reg;
  logic           stall_reg;
  logic [2:0]     replica_rst_reg;
  logic           rollback_en_reg;
  logic [1:0]     fault_id_reg;
  logic           fatal_reg;

  logic       clean;
  logic [1:0] fid;
  logic       retry_max;
  logic       commit_clean;
  logic       ckpt_taken;
  logic       diag;

  assign clean        = (bus.voter_state == VS_CLEAN);
  assign fid          = vs_to_fid(bus.voter_state);
  assign retry_max    = (retry_reg == RW'(MAX_RETRY));
  assign commit_clean = (state_reg == MONITOR) && clean && bus.commit;
  assign diag         = (state_reg == MONITOR) && !clean && !retry_max;

  tmr_ckpt_tracker #(
    .CKPT_INTERVAL(CKPT_INTERVAL),
    .RESET_PC     (RESET_PC)
  ) u_ckpt (
    .clk         (clk),
    .rst_in      (rst_in),
    .commit_clean(commit_clean),
    .clear       (state_reg == ROLLBACK),
    .pc_voted    (bus.pc_voted),
    .ckpt_taken  (ckpt_taken),
    .rollback_pc (bus.rollback_pc)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_reg       <= MONITOR;
      retry_reg       <= '0;
      rs_cnt_reg      <= '0;
      stall_reg       <= 1'b0;
      replica_rst_reg <= 3'b000;
      rollback_en_reg <= 1'b0;
      fault_id_reg    <= FID_NONE;
      fatal_reg       <= 1'b0;
    end else begin
      case (state_reg)
        MONITOR: begin
          if (ckpt_taken) begin
            retry_reg <= '0;
          end else if (!clean) begin
            stall_reg <= 1'b1;
            if (retry_max) begin
              state_reg       <= FATAL;
              fatal_reg       <= 1'b1;
              replica_rst_reg <= 3'b111;
            end else begin
              retry_reg    <= retry_reg + 1'b1;
              fault_id_reg <= fid;
              if (fid == FID_NONE) begin
                state_reg       <= ROLLBACK;
                rollback_en_reg <= 1'b1;
              end else begin
                state_reg       <= RESYNC;
                replica_rst_reg <= fid_to_rst(fid);
                rs_cnt_reg      <= RCW'(1);
              end
            end
          end
        end
        RESYNC: begin
          // rs_cnt_reg counts the reset cycles already shown on replica_rst.
          if (rs_cnt_reg == RCW'(RESYNC_CYCLES)) begin
            state_reg       <= ROLLBACK;
            replica_rst_reg <= 3'b000;
            rollback_en_reg <= 1'b1;
          end else begin
            rs_cnt_reg <= rs_cnt_reg + 1'b1;
          end
        end
        ROLLBACK: begin
          state_reg       <= MONITOR;
          stall_reg       <= 1'b0;
          rollback_en_reg <= 1'b0;
        end
        default: begin
          state_reg <= FATAL;
        end
      endcase
    end
  end

  assign bus.stall       = stall_reg;
  assign bus.replica_rst = replica_rst_reg;
  assign bus.rollback_en = rollback_en_reg;
  assign bus.fault_id    = fault_id_reg;
  assign bus.fatal       = fatal_reg;

`ifdef TMR_ERR_LOG_EN
  // Counter index matches the fault id, so index 3 is the multi/no-majority count.
  for (genvar gi = 0; gi < 4; gi++) begin : gen_err
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (rst_in) begin
        cnt_reg <= '0;
      end else if (diag && (fid == 2'(gi)) && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
  assign bus.err_cnt_a     = gen_err[0].cnt_reg;
  assign bus.err_cnt_b     = gen_err[1].cnt_reg;
  assign bus.err_cnt_c     = gen_err[2].cnt_reg;
  assign bus.err_cnt_multi = gen_err[3].cnt_reg;
`else
  logic unused_diag;
  assign unused_diag = diag;
`endif
endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Directed bench for tmr_recovery_ctrl: reset, checkpointing, single and
// multi fault recovery, retry exhaustion and reset during resync.
module tb_tmr_recovery_ctrl;
  logic clk;
  logic rst_in;
  int   total = 0;
  int   bad   = 0;

`ifdef TMR_ERR_LOG_EN
  tmr_recovery_ctrl_if #(.CNT_W(8)) bus ();
`else
  tmr_recovery_ctrl_if bus ();
`endif

  tmr_recovery_ctrl dut (
    .clk   (clk),
    .rst_in(rst_in),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] vs, input logic c, input logic [31:0] pc);
    bus.voter_state = vs;
    bus.commit      = c;
    bus.pc_voted    = pc;
  endtask

  // Single-fault window with RESYNC_CYCLES=4: reset N+1..N+4, rollback N+5, release N+6.
  task automatic single_fault(input logic [2:0] vs, input logic [2:0] exp_rst,
                              input logic [1:0] exp_fid, input logic [31:0] exp_pc);
    drive(vs, 1'b0, 32'h0);
    tick();
    check("sf_fault_id", 32'(bus.fault_id), 32'(exp_fid));
    check("sf_stall_n1", 32'(bus.stall), 32'd1);
    check("sf_rst_n1", 32'(bus.replica_rst), 32'(exp_rst));
    drive(3'b111, 1'b1, 32'hdead);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("sf_rst_n%0d", i), 32'(bus.replica_rst), 32'(exp_rst));
    end
    tick();
    check("sf_rb_en", 32'(bus.rollback_en), 32'd1);
    check("sf_rb_pc", bus.rollback_pc, exp_pc);
    check("sf_rst_off", 32'(bus.replica_rst), 32'd0);
    check("sf_stall_n5", 32'(bus.stall), 32'd1);
    drive(3'b111, 1'b0, 32'h0);
    tick();
    check("sf_stall_n6", 32'(bus.stall), 32'd0);
    check("sf_rb_en_off", 32'(bus.rollback_en), 32'd0);
  endtask

  task automatic commits(input int n, input logic [31:0] last_pc);
    for (int i = 1; i <= n; i++) begin
      drive(3'b111, 1'b1, (i == n) ? last_pc : 32'h1000 + 32'(i));
      tick();
    end
    drive(3'b111, 1'b0, 32'h0);
  endtask

  initial begin
    rst_in = 1'b1;
    drive(3'b111, 1'b0, 32'h0);
    tick();
    tick();
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_replica_rst", 32'(bus.replica_rst), 32'd0);
    check("rst_rb_en", 32'(bus.rollback_en), 32'd0);
    check("rst_rb_pc", bus.rollback_pc, 32'h0);
    check("rst_fault_id", 32'(bus.fault_id), 32'd3);
    check("rst_fatal", 32'(bus.fatal), 32'd0);
    rst_in = 1'b0;

    commits(15, 32'h2222);
    check("ckpt_15_unchanged", bus.rollback_pc, 32'h0);
    commits(1, 32'h40);
    check("ckpt_16_capture", bus.rollback_pc, 32'h40);

    single_fault(3'b010, 3'b100, 2'd0, 32'h40);

    // Commits offered during recovery must not count toward the next checkpoint.
    commits(15, 32'h3333);
    check("ckpt_after_rb_15", bus.rollback_pc, 32'h40);
    commits(1, 32'h80);
    check("ckpt_after_rb_16", bus.rollback_pc, 32'h80);

    drive(3'b000, 1'b0, 32'h0);
    tick();
    check("multi_fault_id", 32'(bus.fault_id), 32'd3);
    check("multi_rst", 32'(bus.replica_rst), 32'd0);
    check("multi_rb_en", 32'(bus.rollback_en), 32'd1);
    check("multi_stall", 32'(bus.stall), 32'd1);
    drive(3'b111, 1'b0, 32'h0);
    tick();
    check("multi_stall_off", 32'(bus.stall), 32'd0);
    check("multi_rb_en_off", 32'(bus.rollback_en), 32'd0);

    single_fault(3'b001, 3'b010, 2'd1, 32'h80);
    single_fault(3'b100, 3'b001, 2'd2, 32'h80);
    check("pre_fatal", 32'(bus.fatal), 32'd0);

    drive(3'b110, 1'b0, 32'h0);
    tick();
    check("fatal_set", 32'(bus.fatal), 32'd1);
    check("fatal_rst", 32'(bus.replica_rst), 32'h7);
    check("fatal_stall", 32'(bus.stall), 32'd1);
    drive(3'b111, 1'b1, 32'h0);
    for (int i = 0; i < 20; i++) tick();
    check("fatal_hold", 32'(bus.fatal), 32'd1);
    check("fatal_hold_rst", 32'(bus.replica_rst), 32'h7);
    check("fatal_hold_stall", 32'(bus.stall), 32'd1);
    check("fatal_no_rb", 32'(bus.rollback_en), 32'd0);
    drive(3'b111, 1'b0, 32'h0);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("fatal_clr", 32'(bus.fatal), 32'd0);
    check("fatal_clr_rst", 32'(bus.replica_rst), 32'd0);
    check("fatal_clr_pc", bus.rollback_pc, 32'h0);

    drive(3'b010, 1'b0, 32'h0);
    tick();
    drive(3'b111, 1'b0, 32'h0);
    tick();
    check("mid_rst_win2", 32'(bus.replica_rst), 32'h4);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("mid_rst_rr", 32'(bus.replica_rst), 32'd0);
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_rb", 32'(bus.rollback_en), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_rst_no_pulse", 32'(bus.rollback_en), 32'd0);
    end
    check("mid_rst_stall_after", 32'(bus.stall), 32'd0);

    single_fault(3'b100, 3'b001, 2'd2, 32'h0);
    single_fault(3'b100, 3'b001, 2'd2, 32'h0);
`ifdef TMR_ERR_LOG_EN
    check("err_cnt_c", 32'(bus.err_cnt_c), 32'd2);
    check("err_cnt_a", 32'(bus.err_cnt_a), 32'd0);
    check("err_cnt_multi", 32'(bus.err_cnt_multi), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
